// File: rtl/gpr_wb_arbiter.sv
// Register-file writeback arbiter: round-robin grant between two result paths,
// one-cycle registered write port, and a pending-write scoreboard for decode hazards.
module gpr_wb_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [4:0]  a_rw,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_rw,
  input  logic [31:0] b_data,
  output logic        b_ready,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rw,
  input  logic        flush,
  input  logic [4:0]  chk_ra,
  input  logic [4:0]  chk_rb,
  output logic        chk_hazard,
  output logic        RegWr,
  output logic [4:0]  rw,
  output logic [31:0] busW,
  output logic [31:0] busy
);

  // prefer_b is set when A won the last transfer, so B wins the next contention
  logic        prefer_b;
  logic        grant_a;
  logic        grant_b;
  logic        xfer;
  logic        xfer_wr;
  logic [4:0]  sel_rw;
  logic [31:0] sel_data;
  logic [31:0] busy_next;

  assign grant_a  = !rst && a_valid && (!b_valid || !prefer_b);
  assign grant_b  = !rst && b_valid && (!a_valid || prefer_b);
  assign a_ready  = grant_a;
  assign b_ready  = grant_b;
  assign xfer     = grant_a | grant_b;
  assign sel_rw   = grant_b ? b_rw : a_rw;
  assign sel_data = grant_b ? b_data : a_data;
  assign xfer_wr  = xfer && (sel_rw != 5'd0);

  assign chk_hazard = busy[chk_ra] | busy[chk_rb];

  // Priority, lowest to highest: retire clear, issue set, flush
  always_comb begin
    busy_next = busy;
    if (xfer_wr)
      busy_next[sel_rw] = 1'b0;
    if (iss_valid && (iss_rw != 5'd0))
      busy_next[iss_rw] = 1'b1;
    if (flush)
      busy_next = '0;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prefer_b <= 1'b0;
      RegWr    <= 1'b0;
      rw       <= '0;
      busW     <= '0;
      busy     <= '0;
    end else begin
      if (xfer)
        prefer_b <= grant_a;
      RegWr <= xfer_wr;
      // Writes to r0 are consumed but leave the write port untouched
      if (xfer_wr) begin
        rw   <= sel_rw;
        busW <= sel_data;
      end
      busy <= busy_next;
    end
  end

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed self-checking bench for gpr_wb_arbiter: arbitration, write port
// latency, scoreboard set/clear/flush priority and reset behaviour.
module tb_gpr_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        a_valid;
  logic [4:0]  a_rw;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_rw;
  logic [31:0] b_data;
  logic        b_ready;
  logic        iss_valid;
  logic [4:0]  iss_rw;
  logic        flush;
  logic [4:0]  chk_ra;
  logic [4:0]  chk_rb;
  logic        chk_hazard;
  logic        RegWr;
  logic [4:0]  rw;
  logic [31:0] busW;
  logic [31:0] busy;

  int checks = 0;
  int errors = 0;

  gpr_wb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .a_valid    (a_valid),
    .a_rw       (a_rw),
    .a_data     (a_data),
    .a_ready    (a_ready),
    .b_valid    (b_valid),
    .b_rw       (b_rw),
    .b_data     (b_data),
    .b_ready    (b_ready),
    .iss_valid  (iss_valid),
    .iss_rw     (iss_rw),
    .flush      (flush),
    .chk_ra     (chk_ra),
    .chk_rb     (chk_rb),
    .chk_hazard (chk_hazard),
    .RegWr      (RegWr),
    .rw         (rw),
    .busW       (busW),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic av, input logic [4:0] arw, input logic [31:0] ad,
                               input logic bv, input logic [4:0] brw, input logic [31:0] bd);
    a_valid = av;
    a_rw    = arw;
    a_data  = ad;
    b_valid = bv;
    b_rw    = brw;
    b_data  = bd;
  endtask

  // Advance past the next rising edge and settle the registered outputs
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    stepCycle();
    stepCycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    iss_valid = 1'b0;
    iss_rw = '0;
    flush = 1'b0;
    chk_ra = '0;
    chk_rb = '0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    stepCycle();
    stepCycle();

    // Reset state, and no grant while reset is held
    checkOutput("rst_regwr", {31'b0, RegWr}, 32'h0);
    checkOutput("rst_rw", {27'b0, rw}, 32'h0);
    checkOutput("rst_busw", busW, 32'h0);
    checkOutput("rst_busy", busy, 32'h0);
    applyStimulus(1'b1, 5'd5, 32'h1234, 1'b1, 5'd6, 32'h5678);
    #1;
    checkOutput("rst_aready", {31'b0, a_ready}, 32'h0);
    checkOutput("rst_bready", {31'b0, b_ready}, 32'h0);
    stepCycle();
    checkOutput("rst_noxfer", {31'b0, RegWr}, 32'h0);

    // Single A write: one-cycle latency then RegWr drops, rw/busW hold
    rst = 1'b0;
    applyStimulus(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0);
    #1;
    checkOutput("single_aready", {31'b0, a_ready}, 32'h1);
    checkOutput("single_bready", {31'b0, b_ready}, 32'h0);
    stepCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("single_regwr", {31'b0, RegWr}, 32'h1);
    checkOutput("single_rw", {27'b0, rw}, 32'd5);
    checkOutput("single_busw", busW, 32'h1234);
    stepCycle();
    checkOutput("idle_regwr", {31'b0, RegWr}, 32'h0);
    checkOutput("idle_rw_hold", {27'b0, rw}, 32'd5);
    checkOutput("idle_busw_hold", busW, 32'h1234);

    // Continuous contention alternates A,B,A,B starting with A after reset
    doReset();
    applyStimulus(1'b1, 5'd3, 32'h0000_00A3, 1'b1, 5'd4, 32'h0000_00B4);
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput("rr_aready", {31'b0, a_ready}, (i % 2 == 0) ? 32'h1 : 32'h0);
      checkOutput("rr_bready", {31'b0, b_ready}, (i % 2 == 0) ? 32'h0 : 32'h1);
      stepCycle();
      checkOutput("rr_regwr", {31'b0, RegWr}, 32'h1);
      checkOutput("rr_rw", {27'b0, rw}, (i % 2 == 0) ? 32'd3 : 32'd4);
      checkOutput("rr_busw", busW, (i % 2 == 0) ? 32'hA3 : 32'hB4);
    end
    // B won last, yet a lone B request is still granted immediately
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h0000_00B4);
    #1;
    checkOutput("lone_b_ready", {31'b0, b_ready}, 32'h1);
    checkOutput("lone_b_aready", {31'b0, a_ready}, 32'h0);
    stepCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Issue sets busy[7]; hazard seen on either source; B retire clears it
    iss_valid = 1'b1;
    iss_rw = 5'd7;
    stepCycle();
    iss_valid = 1'b0;
    checkOutput("iss7_busy", busy, 32'h0000_0080);
    chk_ra = 5'd7;
    chk_rb = 5'd0;
    #1;
    checkOutput("haz_ra", {31'b0, chk_hazard}, 32'h1);
    chk_ra = 5'd1;
    chk_rb = 5'd7;
    #1;
    checkOutput("haz_rb", {31'b0, chk_hazard}, 32'h1);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hCAFE_0007);
    #1;
    checkOutput("ret7_bready", {31'b0, b_ready}, 32'h1);
    checkOutput("haz_nobypass", {31'b0, chk_hazard}, 32'h1);
    stepCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("ret7_busy", busy, 32'h0);
    checkOutput("ret7_haz", {31'b0, chk_hazard}, 32'h0);
    checkOutput("ret7_rw", {27'b0, rw}, 32'd7);
    checkOutput("ret7_busw", busW, 32'hCAFE_0007);

    // Same-edge set and clear of r9: set wins
    iss_valid = 1'b1;
    iss_rw = 5'd9;
    stepCycle();
    checkOutput("iss9_busy", busy, 32'h0000_0200);
    applyStimulus(1'b1, 5'd9, 32'h0000_0009, 1'b0, 5'd0, 32'h0);
    stepCycle();
    iss_valid = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("setwin_busy", busy, 32'h0000_0200);
    checkOutput("setwin_regwr", {31'b0, RegWr}, 32'h1);
    applyStimulus(1'b1, 5'd9, 32'h0000_0099, 1'b0, 5'd0, 32'h0);
    stepCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("ret9_busy", busy, 32'h0);

    // r0 writes are consumed without a write; issues to r0 are ignored
    iss_valid = 1'b1;
    iss_rw = 5'd3;
    stepCycle();
    iss_rw = 5'd0;
    applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0);
    #1;
    checkOutput("r0_aready", {31'b0, a_ready}, 32'h1);
    stepCycle();
    iss_valid = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("r0_regwr", {31'b0, RegWr}, 32'h0);
    checkOutput("r0_busy", busy, 32'h0000_0008);
    chk_ra = 5'd0;
    chk_rb = 5'd0;
    #1;
    checkOutput("r0_haz", {31'b0, chk_hazard}, 32'h0);

    // Flush overrides a same-edge issue but leaves the write port alone
    flush = 1'b1;
    stepCycle();
    flush = 1'b0;
    checkOutput("flush_alone", busy, 32'h0);
    iss_valid = 1'b1;
    for (int r = 4; r < 8; r++) begin
      iss_rw = 5'(r);
      stepCycle();
    end
    checkOutput("pre_flush_busy", busy, 32'h0000_00F0);
    flush = 1'b1;
    iss_rw = 5'd2;
    applyStimulus(1'b1, 5'd5, 32'h5555_0005, 1'b0, 5'd0, 32'h0);
    stepCycle();
    flush = 1'b0;
    iss_valid = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("flush_busy", busy, 32'h0);
    checkOutput("flush_regwr", {31'b0, RegWr}, 32'h1);
    checkOutput("flush_busw", busW, 32'h5555_0005);

    // Reset right after a transfer drops the pending write
    applyStimulus(1'b1, 5'd12, 32'h0000_000C, 1'b0, 5'd0, 32'h0);
    stepCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    rst = 1'b1;
    checkOutput("prerst_regwr", {31'b0, RegWr}, 32'h1);
    stepCycle();
    rst = 1'b0;
    checkOutput("droprst_regwr", {31'b0, RegWr}, 32'h0);
    checkOutput("droprst_rw", {27'b0, rw}, 32'h0);
    checkOutput("droprst_busw", busW, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gpr_wb_arbiter.md
GPR_WB_ARBITER -- requirements
Module: gpr_wb_arbiter

Interface
REQ-001 Parameters: none; data width is fixed at 32 bits and register index width at 5 bits.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 a_valid  in  1  writeback request from ALU/load path (requester A).
REQ-005 a_rw  in  5  destination register index for A.
REQ-006 a_data  in  32  write data for A.
REQ-007 a_ready  out  1  A's request is granted this cycle (combinational).
REQ-008 b_valid, b_rw, b_data, b_ready: same four signals as REQ-004..007 for the mult/div unit (requester B).
REQ-009 iss_valid  in  1  an instruction with a register destination issues this cycle.
REQ-010 iss_rw  in  5  destination index of the issuing instruction.
REQ-011 flush  in  1  synchronous clear of all scoreboard busy bits.
REQ-012 chk_ra, chk_rb  in  5 each  source indices of the instruction in decode.
REQ-013 chk_hazard  out  1  either source register has a pending write (combinational).
REQ-014 RegWr  out  1  registered write enable to the register file.
REQ-015 rw  out  5  registered write index to the register file.
REQ-016 busW  out  32  registered write data to the register file.
REQ-017 busy  out  32  scoreboard vector; bit n = register n has a pending write.

Function
REQ-018 A transfer occurs on a requester when valid and ready are both 1 at a clock edge; the requester SHALL hold valid, rw and data stable until that transfer.
REQ-019 At most one of a_ready/b_ready SHALL be 1 in any cycle; ready SHALL never be 1 without the matching valid.
REQ-020 Only one requester valid: that requester SHALL be granted the same cycle.
REQ-021 Both requesters valid: grant SHALL follow round-robin from a 1-bit last-grant pointer; the requester not granted last wins.
REQ-022 The pointer SHALL update only on a transfer, recording the granted requester.
REQ-023 A transfer at edge N SHALL present RegWr=1, rw, busW at the outputs for exactly the cycle after edge N (1-cycle latency).
REQ-024 With no transfer at edge N, RegWr SHALL be 0 after edge N; rw and busW SHALL hold their previous values.
REQ-025 A transfer with rw=0 SHALL be consumed (ready asserted) but SHALL produce RegWr=0 and SHALL not modify busy.
REQ-026 iss_valid=1 with iss_rw!=0 SHALL set busy[iss_rw] at the edge; iss_rw=0 SHALL be ignored.
REQ-027 A transfer with rw!=0 SHALL clear busy[rw] at the transfer edge.
REQ-028 Set and clear of the same index at the same edge: set SHALL win and busy stays 1.
REQ-029 flush=1 SHALL clear all busy bits at the edge and SHALL override simultaneous sets and clears; arbitration and output registers are unaffected.
REQ-030 busy[0] SHALL always read 0.
REQ-031 chk_hazard SHALL equal busy[chk_ra] OR busy[chk_rb], evaluated on the current registered busy vector with no bypass of same-cycle transfers.
REQ-032 Two requesters with the same rw SHALL each be arbitrated normally; each transfer clears that busy bit.

Reset
REQ-033 When rst=1 at an edge: RegWr=0, rw=0, busW=0, busy=0, and the pointer is set so A wins the first contention.
REQ-034 During reset cycles a_ready and b_ready SHALL be 0 and no transfer SHALL occur.
REQ-035 Reset asserted in the cycle after a transfer SHALL force RegWr=0 on the next edge, dropping that write.

Verification
REQ-036 Reset, then a_valid=1, a_rw=5, a_data=32'h1234 for one cycle -> a_ready=1 in that cycle; next cycle RegWr=1, rw=5, busW=32'h1234; the cycle after, RegWr=0.
REQ-037 Reset, then A and B both valid continuously (a_rw=3, b_rw=4) -> grants alternate A,B,A,B; RegWr stays 1 with rw sequence 3,4,3,4.
REQ-038 iss_valid=1, iss_rw=7 -> busy[7]=1; chk_ra=7 gives chk_hazard=1; B transfer with rw=7 -> busy[7]=0 on the next cycle and chk_hazard=0.
REQ-039 Same edge: iss_rw=9 and A transfer with rw=9 while busy[9]=1 -> busy[9] remains 1.
REQ-040 A transfer with rw=0 and data 32'hFFFF_FFFF -> a_ready=1, next-cycle RegWr=0, busy unchanged; iss_rw=0 -> busy[0] stays 0.
REQ-041 busy=32'h0000_00F0 and flush=1 together with iss_rw=2 -> busy=0 after the edge.
